// File: rtl/scan_sel_gen_if.sv
// Control and select bus between a scan controller and scan_sel_gen.
// master drives the controls; slave (the generator) drives the decoder select and status.
interface scan_sel_gen_if;
  logic       start;
  logic       stop;
  logic       dir;
  logic       load;
  logic [1:0] load_val;
  logic       a;
  logic       b;
  logic       out_en;
  logic       wrap;
  logic       busy;

  modport master (
    output start, stop, dir, load, load_val,
    input  a, b, out_en, wrap, busy
  );

  modport slave (
    input  start, stop, dir, load, load_val,
    output a, b, out_en, wrap, busy
  );
endinterface

// File: rtl/scan_sel_gen.sv
// 2-bit scan select generator for a 2-to-4 decoder, with prescaled dwell per code.
// Define SCAN_BLANK_EN to insert BLANK_CYC blanking cycles between codes.
module scan_sel_gen #(
  parameter int unsigned PRESCALE  = 4,
  parameter int unsigned BLANK_CYC = 1
) (
  input logic          clk_i,
  input logic          rst_ni,
  scan_sel_gen_if.slave bus
);

  localparam int unsigned     CntW    = $clog2(PRESCALE + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(PRESCALE - 1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StDwell = 2'd1;
`ifdef SCAN_BLANK_EN
  localparam logic [1:0] StBlank = 2'd2;

  localparam int unsigned     BlkW    = $clog2(BLANK_CYC + 1);
  localparam logic [BlkW-1:0] BlkLast = BlkW'(BLANK_CYC - 1);

  logic [BlkW-1:0] blank_q, blank_d;
`endif

  logic [1:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      sel_q, sel_d;
  logic            wrap_q, wrap_d;
  logic            out_en_q;
  logic            busy_q;

  logic [1:0]      sel_adv;
  logic            wrap_adv;

  // dir only matters where sel_adv is consumed, i.e. on the advance cycle.
  always_comb begin
    sel_adv  = bus.dir ? (sel_q - 2'd1) : (sel_q + 2'd1);
    wrap_adv = bus.dir ? (sel_q == 2'd0) : (sel_q == 2'd3);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    wrap_d  = 1'b0;
`ifdef SCAN_BLANK_EN
    blank_d = blank_q;
`endif
    if (bus.stop) begin
      state_d = StIdle;
    end else if (bus.load) begin
      sel_d = bus.load_val;
      if (state_q != StIdle) begin
        state_d = StDwell;
        cnt_d   = '0;
      end
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.start) begin
            state_d = StDwell;
            cnt_d   = '0;
          end
        end
        StDwell: begin
          if (cnt_q == CntLast) begin
`ifdef SCAN_BLANK_EN
            state_d = StBlank;
            blank_d = '0;
`else
            sel_d   = sel_adv;
            wrap_d  = wrap_adv;
            cnt_d   = '0;
`endif
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
`ifdef SCAN_BLANK_EN
        StBlank: begin
          if (blank_q == BlkLast) begin
            sel_d   = sel_adv;
            wrap_d  = wrap_adv;
            state_d = StDwell;
            cnt_d   = '0;
          end else begin
            blank_d = blank_q + 1'b1;
          end
        end
`endif
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      sel_q    <= 2'd0;
      wrap_q   <= 1'b0;
      out_en_q <= 1'b0;
      busy_q   <= 1'b0;
`ifdef SCAN_BLANK_EN
      blank_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      wrap_q   <= wrap_d;
      out_en_q <= (state_d == StDwell);
      busy_q   <= (state_d != StIdle);
`ifdef SCAN_BLANK_EN
      blank_q  <= blank_d;
`endif
    end
  end

  assign bus.a      = sel_q[1];
  assign bus.b      = sel_q[0];
  assign bus.out_en = out_en_q;
  assign bus.wrap   = wrap_q;
  assign bus.busy   = busy_q;

endmodule

// File: tb/tb_scan_sel_gen.sv
// Directed self-checking bench for scan_sel_gen (PRESCALE=4, BLANK_CYC=2).
// Observed vector is {a, b, out_en, wrap, busy}.
module tb_scan_sel_gen;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  scan_sel_gen_if bus ();

  scan_sel_gen #(
    .PRESCALE  (4),
    .BLANK_CYC (2)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  logic [4:0] obs;
  assign obs = {bus.a, bus.b, bus.out_en, bus.wrap, bus.busy};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bus.start = 1'b0; bus.stop = 1'b0; bus.dir = 1'b0;
    bus.load = 1'b0; bus.load_val = 2'd0;
    step();
    checks++;
    if (obs !== 5'b00000) begin
      errors++; $display("FAIL reset got %b want %b", obs, 5'b00000);
    end
    bus.start = 1'b1;
    step();
    checks++;
    if (obs !== 5'b00000) begin
      errors++; $display("FAIL reset_over_start got %b want %b", obs, 5'b00000);
    end
    rst_n = 1'b1; bus.start = 1'b0;
    step();
    checks++;
    if (obs !== 5'b00000) begin
      errors++; $display("FAIL idle_after_reset got %b want %b", obs, 5'b00000);
    end
  endtask

`ifndef SCAN_BLANK_EN
  task automatic test_scan_up();
    logic [4:0] exp;
    logic [1:0] s;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int k = 0; k <= 16; k++) begin
      if (k > 0) step();
      s   = 2'((k / 4) % 4);
      exp = {s, 1'b1, (k == 16), 1'b1};
      checks++;
      if (obs !== exp) begin
        errors++; $display("FAIL scan_up k=%0d got %b want %b", k, obs, exp);
      end
    end
  endtask

  task automatic test_stop();
    step(); step(); step();
    bus.stop = 1'b1;
    step();
    checks++;
    if (obs !== 5'b00000) begin
      errors++; $display("FAIL stop_at_advance got %b want %b", obs, 5'b00000);
    end
    bus.stop = 1'b0;
    step();
    checks++;
    if (obs !== 5'b00000) begin
      errors++; $display("FAIL stop_hold got %b want %b", obs, 5'b00000);
    end
    bus.start = 1'b1; bus.stop = 1'b1;
    step();
    checks++;
    if (obs !== 5'b00000) begin
      errors++; $display("FAIL stop_over_start got %b want %b", obs, 5'b00000);
    end
    bus.start = 1'b0; bus.stop = 1'b0;
  endtask

  task automatic test_dir_down();
    logic [4:0] exp;
    logic [1:0] s;
    bus.load = 1'b1; bus.load_val = 2'd1;
    step();
    checks++;
    if (obs !== 5'b01000) begin
      errors++; $display("FAIL load_idle got %b want %b", obs, 5'b01000);
    end
    bus.load = 1'b0; bus.dir = 1'b1; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    checks++;
    if (obs !== 5'b01101) begin
      errors++; $display("FAIL down_start got %b want %b", obs, 5'b01101);
    end
    for (int k = 1; k <= 12; k++) begin
      if (k == 10) bus.dir = 1'b0;
      step();
      s   = (k < 4) ? 2'd1 : (k < 8) ? 2'd0 : (k < 12) ? 2'd3 : 2'd0;
      exp = {s, 1'b1, (k == 8 || k == 12), 1'b1};
      checks++;
      if (obs !== exp) begin
        errors++; $display("FAIL dir_down k=%0d got %b want %b", k, obs, exp);
      end
    end
  endtask

  task automatic test_load_advance();
    logic [4:0] exp;
    bus.load = 1'b1; bus.load_val = 2'd3;
    step();
    bus.load = 1'b0;
    step(); step(); step();
    checks++;
    if (obs !== 5'b11101) begin
      errors++; $display("FAIL load_code3 got %b want %b", obs, 5'b11101);
    end
    bus.load = 1'b1; bus.load_val = 2'd2;
    step();
    bus.load = 1'b0;
    checks++;
    if (obs !== 5'b10101) begin
      errors++; $display("FAIL load_vs_advance got %b want %b", obs, 5'b10101);
    end
    for (int m = 1; m <= 4; m++) begin
      step();
      exp = (m < 4) ? 5'b10101 : 5'b11101;
      checks++;
      if (obs !== exp) begin
        errors++; $display("FAIL dwell_after_load m=%0d got %b want %b", m, obs, exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    step(); step(); step();
    checks++;
    if (obs !== 5'b11101) begin
      errors++; $display("FAIL pre_reset got %b want %b", obs, 5'b11101);
    end
    rst_n = 1'b0;
    step();
    checks++;
    if (obs !== 5'b00000) begin
      errors++; $display("FAIL reset_mid got %b want %b", obs, 5'b00000);
    end
    rst_n = 1'b1;
    step();
    checks++;
    if (obs !== 5'b00000) begin
      errors++; $display("FAIL reset_mid_idle got %b want %b", obs, 5'b00000);
    end
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    checks++;
    if (obs !== 5'b00101) begin
      errors++; $display("FAIL restart_code0 got %b want %b", obs, 5'b00101);
    end
  endtask
`else
  task automatic test_blank();
    logic [4:0] exp;
    logic [1:0] s;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int k = 0; k <= 28; k++) begin
      if (k > 0) step();
      s   = 2'((k / 6) % 4);
      exp = {s, ((k % 6) < 4), (k == 24), 1'b1};
      checks++;
      if (obs !== exp) begin
        errors++; $display("FAIL blank_scan k=%0d got %b want %b", k, obs, exp);
      end
    end
  endtask

  task automatic test_stop_load_blank();
    bus.stop = 1'b1; bus.load = 1'b1; bus.load_val = 2'd2;
    step();
    bus.stop = 1'b0; bus.load = 1'b0;
    checks++;
    if (obs !== 5'b00000) begin
      errors++; $display("FAIL stop_load_in_blank got %b want %b", obs, 5'b00000);
    end
  endtask

  task automatic test_load_blank();
    logic [4:0] exp;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step(); step(); step(); step();
    checks++;
    if (obs !== 5'b00001) begin
      errors++; $display("FAIL enter_blank got %b want %b", obs, 5'b00001);
    end
    bus.load = 1'b1; bus.load_val = 2'd3;
    step();
    bus.load = 1'b0;
    checks++;
    if (obs !== 5'b11101) begin
      errors++; $display("FAIL load_in_blank got %b want %b", obs, 5'b11101);
    end
    for (int m = 1; m <= 6; m++) begin
      step();
      exp = (m < 4) ? 5'b11101 : (m < 6) ? 5'b11001 : 5'b00111;
      checks++;
      if (obs !== exp) begin
        errors++; $display("FAIL after_load_blank m=%0d got %b want %b", m, obs, exp);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
`ifndef SCAN_BLANK_EN
    test_scan_up();
    test_stop();
    test_dir_down();
    test_load_advance();
    test_reset_mid();
`else
    test_blank();
    test_stop_load_blank();
    test_load_blank();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
